// File: rtl/multiplier_t_c1x1_f2_16x16_sidm_if.sv
// Operand/result bundle for the precision-configurable 16x16 multiplier slice.
// Master drives operands, sign flags and mode; slave returns the registered
// redundant product (two 32-bit partial words plus per-lane carry bits).
interface multiplier_t_c1x1_f2_16x16_sidm_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        a_sign;
    logic        b_sign;
    logic [1:0]  mode;
    logic [31:0] result_0;
    logic [31:0] result_1;
    logic [3:0]  result_SIDM_carry;

    modport master (
        output a, b, a_sign, b_sign, mode,
        input  result_0, result_1, result_SIDM_carry
    );

    modport slave (
        input  a, b, a_sign, b_sign, mode,
        output result_0, result_1, result_SIDM_carry
    );
endinterface

// File: rtl/multiplier_t_c1x1_f2_16x16_sidm.sv
// Purpose: precision-configurable multiply (1x16x16, 1x16x16 33-bit, 2x8x8, 4x4x4), redundant-form output.
// Latency: 1 cycle (outputs registered), one new operation accepted every cycle.
// Backpressure: none; the slice is always ready and results are overwritten each cycle.
//
// Ports: clk (rising edge), reset (async, active low), bus (slave modport):
//   a/b operands, a_sign/b_sign per-operand signedness, mode select,
//   result_0/result_1 partial words, result_SIDM_carry per-lane extension bits.
module multiplier_t_c1x1_f2_16x16_sidm (
    input  logic                                    clk,
    input  logic                                    reset,
    multiplier_t_c1x1_f2_16x16_sidm_if.slave        bus
);

    localparam logic [1:0] MODE_16X16     = 2'b00;
    localparam logic [1:0] MODE_SUM_16X16 = 2'b01;
    localparam logic [1:0] MODE_SUM_8X8   = 2'b10;
    localparam logic [1:0] MODE_SUM_4X4   = 2'b11;

    // Every lane splits its multiplier into an unsigned low slice and a
    // sign-extended high slice (pre-shifted into place). Each half gives one
    // partial product: the high one lands in result_0, the low one in
    // result_1. All arithmetic is modulo the field width plus one, so
    // multiplying the sign-extended operands unsigned gives correct two's
    // complement low bits without needing any signed types.

    // ---------------- 16x16 path: 33-bit fields ----------------
    logic [32:0] a_ext_w;
    logic [32:0] b_lo_w;
    logic [32:0] b_hi_w;
    logic [32:0] pp_lo_w;
    logic [32:0] pp_hi_w;

    assign a_ext_w = {{17{bus.a_sign & bus.a[15]}}, bus.a};
    assign b_lo_w  = {25'd0, bus.b[7:0]};
    assign b_hi_w  = {{17{bus.b_sign & bus.b[15]}}, bus.b[15:8], 8'd0};
    assign pp_lo_w = a_ext_w * b_lo_w;
    assign pp_hi_w = a_ext_w * b_hi_w;

    // ---------------- 8x8 lanes: 17-bit fields ----------------
    logic [16:0] a_ext_b [2];
    logic [16:0] b_lo_b  [2];
    logic [16:0] b_hi_b  [2];
    logic [16:0] pp_lo_b [2];
    logic [16:0] pp_hi_b [2];

    for (genvar l = 0; l < 2; l++) begin : g_lane8
        assign a_ext_b[l] = {{9{bus.a_sign & bus.a[8*l+7]}}, bus.a[8*l +: 8]};
        assign b_lo_b[l]  = {13'd0, bus.b[8*l +: 4]};
        assign b_hi_b[l]  = {{9{bus.b_sign & bus.b[8*l+7]}}, bus.b[8*l+4 +: 4], 4'd0};
        assign pp_lo_b[l] = a_ext_b[l] * b_lo_b[l];
        assign pp_hi_b[l] = a_ext_b[l] * b_hi_b[l];
    end

    // ---------------- 4x4 lanes: 9-bit fields ----------------
    logic [8:0] a_ext_n [4];
    logic [8:0] b_lo_n  [4];
    logic [8:0] b_hi_n  [4];
    logic [8:0] pp_lo_n [4];
    logic [8:0] pp_hi_n [4];

    for (genvar l = 0; l < 4; l++) begin : g_lane4
        assign a_ext_n[l] = {{5{bus.a_sign & bus.a[4*l+3]}}, bus.a[4*l +: 4]};
        assign b_lo_n[l]  = {7'd0, bus.b[4*l +: 2]};
        assign b_hi_n[l]  = {{5{bus.b_sign & bus.b[4*l+3]}}, bus.b[4*l+2 +: 2], 2'd0};
        assign pp_lo_n[l] = a_ext_n[l] * b_lo_n[l];
        assign pp_hi_n[l] = a_ext_n[l] * b_hi_n[l];
    end

    // ---------------- Result selection ----------------
    // The carry bit of a field is chosen so that {carry, r0_field} + {0, r1_field}
    // equals hi + lo modulo 2^(field+1): dropping the low partial's top bit
    // from result_1 is compensated by folding it (xor) into the carry.
    logic [31:0] r0_nxt;
    logic [31:0] r1_nxt;
    logic [3:0]  carry_nxt;

    always_comb begin
        r0_nxt    = '0;
        r1_nxt    = '0;
        carry_nxt = '0;
        case (bus.mode)
            MODE_16X16: begin
                r0_nxt = pp_hi_w[31:0];
                r1_nxt = pp_lo_w[31:0];
            end
            MODE_SUM_16X16: begin
                r0_nxt       = pp_hi_w[31:0];
                r1_nxt       = pp_lo_w[31:0];
                carry_nxt[3] = pp_hi_w[32] ^ pp_lo_w[32];
            end
            MODE_SUM_8X8: begin
                for (int l = 0; l < 2; l++) begin
                    r0_nxt[16*l +: 16]   = pp_hi_b[l][15:0];
                    r1_nxt[16*l +: 16]   = pp_lo_b[l][15:0];
                    carry_nxt[2*l+1]     = pp_hi_b[l][16] ^ pp_lo_b[l][16];
                end
            end
            MODE_SUM_4X4: begin
                for (int l = 0; l < 4; l++) begin
                    r0_nxt[8*l +: 8] = pp_hi_n[l][7:0];
                    r1_nxt[8*l +: 8] = pp_lo_n[l][7:0];
                    carry_nxt[l]     = pp_hi_n[l][8] ^ pp_lo_n[l][8];
                end
            end
            default: begin
                r0_nxt    = '0;
                r1_nxt    = '0;
                carry_nxt = '0;
            end
        endcase
    end

    // ---------------- Output registers ----------------
    logic [31:0] r0_q;
    logic [31:0] r1_q;
    logic [3:0]  carry_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_q    <= '0;
            r1_q    <= '0;
            carry_q <= '0;
        end else begin
            r0_q    <= r0_nxt;
            r1_q    <= r1_nxt;
            carry_q <= carry_nxt;
        end
    end

    assign bus.result_0          = r0_q;
    assign bus.result_1          = r1_q;
    assign bus.result_SIDM_carry = carry_q;

endmodule

// File: tb/tb_multiplier_t_c1x1_f2_16x16_sidm.sv
// Testbench for the precision-configurable multiplier slice.
// Directed vectors with hand-computed results, reset checks, then a random
// sweep compared against a lane-product model through the output identities.
module tb_multiplier_t_c1x1_f2_16x16_sidm;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    multiplier_t_c1x1_f2_16x16_sidm_if mif ();

    multiplier_t_c1x1_f2_16x16_sidm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_dat(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Fold the redundant outputs into per-mode lane sums; bits that must be
    // zero (unused carries) are packed above the sums so they get checked too.
    function automatic logic [63:0] pack_obs(input logic [1:0] m, input logic [31:0] r0,
                                             input logic [31:0] r1, input logic [3:0] c);
        logic [63:0] o;
        logic [32:0] s33;
        logic [16:0] s17;
        logic [8:0]  s9;
        o = '0;
        case (m)
            2'b00: begin
                o[31:0]  = r0 + r1;
                o[35:32] = c;
            end
            2'b01: begin
                s33      = {c[3], r0} + {1'b0, r1};
                o[32:0]  = s33;
                o[35:33] = c[2:0];
            end
            2'b10: begin
                for (int l = 0; l < 2; l++) begin
                    s17            = {c[2*l+1], r0[16*l +: 16]} + {1'b0, r1[16*l +: 16]};
                    o[17*l +: 17]  = s17;
                end
                o[34] = c[0];
                o[35] = c[2];
            end
            default: begin
                for (int l = 0; l < 4; l++) begin
                    s9           = {c[l], r0[8*l +: 8]} + {1'b0, r1[8*l +: 8]};
                    o[9*l +: 9]  = s9;
                end
            end
        endcase
        return o;
    endfunction

    function automatic longint ext_val(input logic [15:0] v, input int w, input bit s);
        longint x;
        longint one;
        one = 1;
        x = longint'(v) & ((one << w) - 1);
        if (s && x[w-1]) x = x - (one << w);
        return x;
    endfunction

    function automatic logic [63:0] exp_pack(input logic [1:0] m, input logic [15:0] av,
                                             input logic [15:0] bv, input bit sa, input bit sb);
        logic [63:0] o;
        longint p;
        o = '0;
        case (m)
            2'b00: begin
                p = ext_val(av, 16, sa) * ext_val(bv, 16, sb);
                o[31:0] = p[31:0];
            end
            2'b01: begin
                p = ext_val(av, 16, sa) * ext_val(bv, 16, sb);
                o[32:0] = p[32:0];
            end
            2'b10: begin
                for (int l = 0; l < 2; l++) begin
                    p = ext_val(av >> (8*l), 8, sa) * ext_val(bv >> (8*l), 8, sb);
                    o[17*l +: 17] = p[16:0];
                end
            end
            default: begin
                for (int l = 0; l < 4; l++) begin
                    p = ext_val(av >> (4*l), 4, sa) * ext_val(bv >> (4*l), 4, sb);
                    o[9*l +: 9] = p[8:0];
                end
            end
        endcase
        return o;
    endfunction

    // Drive on the falling edge, let one rising edge capture, sample on the
    // following falling edge.
    task automatic apply(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                         input logic sa, input logic sb);
        @(negedge clk);
        mif.mode   = m;
        mif.a      = av;
        mif.b      = bv;
        mif.a_sign = sa;
        mif.b_sign = sb;
        @(negedge clk);
    endtask

    function automatic logic [63:0] obs_now(input logic [1:0] m);
        return pack_obs(m, mif.result_0, mif.result_1, mif.result_SIDM_carry);
    endfunction

    initial begin
        logic [63:0] exp;
        logic [15:0] av;
        logic [15:0] bv;
        n_vec = 0;
        n_err = 0;

        reset      = 1'b0;
        mif.mode   = 2'b00;
        mif.a      = 16'h1234;
        mif.b      = 16'h5678;
        mif.a_sign = 1'b0;
        mif.b_sign = 1'b0;

        // Outputs must be clear while reset is held, even with clocks running.
        #3;
        chk_dat("reset_words", {mif.result_1, mif.result_0}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_dat("reset_carry", {60'd0, mif.result_SIDM_carry}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- Directed vectors ----------------
        apply(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        chk_dat("m00_uu_ffff", obs_now(2'b00), 64'h0_FFFE0001);

        apply(2'b00, 16'hFFFF, 16'h0002, 1'b1, 1'b1);
        chk_dat("m00_ss_neg1x2", obs_now(2'b00), 64'h0_FFFFFFFE);

        apply(2'b00, 16'h8000, 16'h0001, 1'b1, 1'b0);
        chk_dat("m00_su_min", obs_now(2'b00), 64'h0_FFFF8000);

        apply(2'b01, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
        exp = {28'd0, 3'b000, 33'h1_80008000};
        chk_dat("m01_su", obs_now(2'b01), exp);

        apply(2'b01, 16'h8000, 16'h8000, 1'b1, 1'b1);
        exp = {28'd0, 3'b000, 33'h0_40000000};
        chk_dat("m01_ss_min2", obs_now(2'b01), exp);

        apply(2'b10, 16'h80FF, 16'h80FF, 1'b1, 1'b1);
        exp = {28'd0, 1'b0, 1'b0, 17'h04000, 17'h00001};
        chk_dat("m10_ss", obs_now(2'b10), exp);

        apply(2'b11, 16'hF0F8, 16'hFFFF, 1'b1, 1'b0);
        exp = {28'd0, 9'h1F1, 9'h000, 9'h1F1, 9'h188};
        chk_dat("m11_su", obs_now(2'b11), exp);

        // ---------------- Asynchronous reset mid-stream ----------------
        apply(2'b01, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
        chk_dat("pre_reset", obs_now(2'b01), {28'd0, 3'b000, 33'h1_80008000});
        #2;
        reset = 1'b0;
        #1;
        chk_dat("async_rst_words", {mif.result_1, mif.result_0}, 64'd0);
        chk_dat("async_rst_carry", {60'd0, mif.result_SIDM_carry}, 64'd0);
        @(posedge clk);
        #1;
        chk_dat("rst_hold_words", {mif.result_1, mif.result_0}, 64'd0);
        chk_dat("rst_hold_carry", {60'd0, mif.result_SIDM_carry}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_dat("post_release", obs_now(2'b01), {28'd0, 3'b000, 33'h1_80008000});

        // ---------------- Random sweep ----------------
        for (int m = 0; m < 4; m++) begin
            for (int sg = 0; sg < 4; sg++) begin
                for (int i = 0; i < 100; i++) begin
                    av = 16'($urandom_range(0, 65535));
                    bv = 16'($urandom_range(0, 65535));
                    apply(2'(m), av, bv, sg[1], sg[0]);
                    chk_dat($sformatf("sweep_m%0d_s%0d_a%h_b%h", m, sg, av, bv),
                            obs_now(2'(m)), exp_pack(2'(m), av, bv, sg[1], sg[0]));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
